// File: rtl/booth_pkg.sv
// ============================================================================
// booth_pkg: shared types and default sizing for the Booth multiplier front end
// Rev 1.0
// ============================================================================
`default_nettype none

package booth_pkg;

   localparam int BOOTH_WIDTH   = 8;
   localparam int BOOTH_TIMEOUT = 64;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GRANT = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_RESP  = 3'd4
   } booth_state_e;

endpackage : booth_pkg

`default_nettype wire

// File: rtl/booth_arbiter_if.sv
// ============================================================================
// booth_arbiter_if: requester, multiplier-core and response signals of booth_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface booth_arbiter_if #(
   parameter int WIDTH = booth_pkg::BOOTH_WIDTH
);

   logic               req0;
   logic               req1;
   logic [WIDTH-1:0]   a0;
   logic [WIDTH-1:0]   b0;
   logic [WIDTH-1:0]   a1;
   logic [WIDTH-1:0]   b1;
   logic               gnt0;
   logic               gnt1;

   logic               mul_init;
   logic [WIDTH-1:0]   mul_A;
   logic [WIDTH-1:0]   mul_B;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_result;

   logic               rsp_valid;
   logic               rsp_id;
   logic [2*WIDTH-1:0] rsp_data;
   logic               rsp_err;

   // Arbiter side
   modport slave (
      input  req0, req1, a0, b0, a1, b1, mul_done, mul_result,
      output gnt0, gnt1, mul_init, mul_A, mul_B,
             rsp_valid, rsp_id, rsp_data, rsp_err
   );

   // Requesters plus multiplier core side
   modport master (
      output req0, req1, a0, b0, a1, b1, mul_done, mul_result,
      input  gnt0, gnt1, mul_init, mul_A, mul_B,
             rsp_valid, rsp_id, rsp_data, rsp_err
   );

endinterface : booth_arbiter_if

`default_nettype wire

// File: rtl/booth_arbiter_rr_arb2.sv
// ============================================================================
// rr_arb2: two-input round-robin arbiter, one-hot grant, favours the input not served last
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/booth_arbiter.sv
// ============================================================================
// booth_arbiter: shares one Booth multiplier core between two requesters, with timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module booth_arbiter
   import booth_pkg::*;
#(
   parameter int WIDTH   = BOOTH_WIDTH,
   parameter int TIMEOUT = BOOTH_TIMEOUT
) (
   input  logic            clk,
   input  logic            rst,
   booth_arbiter_if.slave  bus
);

   localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   booth_state_e       state_q, state_d;
   logic               winner_q, winner_d;
   logic               last_q, last_d;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic [WIDTH-1:0]   op_b_q, op_b_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic               rsp_err_q, rsp_err_d;
   logic               rsp_id_q, rsp_id_d;
   logic [1:0]         arb_gnt;

   rr_arb2 u_rr_arb2 (
      .req_i  ({bus.req1, bus.req0}),
      .last_i (last_q),
      .gnt_o  (arb_gnt)
   );

   always_comb begin
      state_d    = state_q;
      winner_d   = winner_q;
      last_d     = last_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      cnt_d      = cnt_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      rsp_id_d   = rsp_id_q;

      case (state_q)
         ST_IDLE: begin
            if (|arb_gnt) begin
               winner_d = arb_gnt[1];
               state_d  = ST_GRANT;
            end
         end

         // Operands are still held by the requester during its grant cycle
         ST_GRANT: begin
            op_a_d  = winner_q ? bus.a1 : bus.a0;
            op_b_d  = winner_q ? bus.b1 : bus.b0;
            state_d = ST_START;
         end

         ST_START: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end

         // A completion on the last allowed cycle still counts as success
         ST_WAIT: begin
            if (bus.mul_done) begin
               rsp_data_d = bus.mul_result;
               rsp_err_d  = 1'b0;
               rsp_id_d   = winner_q;
               state_d    = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               rsp_id_d   = winner_q;
               state_d    = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_RESP: begin
            last_d  = winner_q;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         winner_q   <= 1'b0;
         last_q     <= 1'b1;
         op_a_q     <= '0;
         op_b_q     <= '0;
         cnt_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         rsp_id_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         winner_q   <= winner_d;
         last_q     <= last_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         cnt_q      <= cnt_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         rsp_id_q   <= rsp_id_d;
      end
   end

   // Pulses decode straight from the state register, so each lasts one cycle
   assign bus.gnt0      = (state_q == ST_GRANT) && !winner_q;
   assign bus.gnt1      = (state_q == ST_GRANT) &&  winner_q;
   assign bus.mul_init  = (state_q == ST_START);
   assign bus.rsp_valid = (state_q == ST_RESP);
   assign bus.mul_A     = op_a_q;
   assign bus.mul_B     = op_b_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule : booth_arbiter

`default_nettype wire

// File: doc/booth_arbiter.md
BOOTH_ARBITER -- requirements
Module: booth_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; product width is 2*WIDTH.
REQ-002 Parameter TIMEOUT, default 64, maximum cycles spent waiting for mul_done before aborting.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; one clock, reset is asynchronous and active-high.
REQ-005 req0, req1  input  1 each  requester operation request; held high until the matching grant.
REQ-006 a0, b0, a1, b1  input  WIDTH each  signed multiplicand/multiplier per requester.
REQ-007 gnt0, gnt1  output  1 each  one-cycle pulse: request accepted, operands sampled.
REQ-008 mul_init  output  1  one-cycle start pulse to the Booth multiplier core.
REQ-009 mul_A, mul_B  output  WIDTH each  operands presented to the core.
REQ-010 mul_done  input  1  core completion flag.
REQ-011 mul_result  input  2*WIDTH  core signed product, valid while mul_done is high.
REQ-012 rsp_valid  output  1  one-cycle pulse: response available.
REQ-013 rsp_id  output  1  requester served (0 or 1); valid with rsp_valid.
REQ-014 rsp_data  output  2*WIDTH  registered product; valid with rsp_valid.
REQ-015 rsp_err  output  1  timeout flag; valid with rsp_valid.

Function
REQ-016 FSM states: IDLE, GRANT, START, WAIT, RESP; one-hot or enum encoding is implementation choice.
REQ-017 IDLE: if any req high at clock edge, latch winner, go GRANT; else stay.
REQ-018 Arbitration is round-robin: when both requests are high, grant the requester not served last; after reset, requester 0 has priority.
REQ-019 GRANT (1 cycle): assert gnt of winner; load winner's a/b into operand registers; go START.
REQ-020 mul_A/mul_B are driven from operand registers and stay stable from START through WAIT.
REQ-021 START (1 cycle): mul_init=1; clear timeout counter; go WAIT.
REQ-022 WAIT: increment timeout counter each cycle; on mul_done=1, capture mul_result into rsp_data, set rsp_err=0, go RESP.
REQ-023 WAIT: if counter reaches TIMEOUT-1 with mul_done=0, set rsp_data=0, rsp_err=1, go RESP.
REQ-024 mul_done and timeout in the same cycle: mul_done wins (rsp_err=0, product captured).
REQ-025 RESP (1 cycle): rsp_valid=1, rsp_id=winner; update last-served pointer; go IDLE.
REQ-026 Requests arriving outside IDLE are not granted; they remain pending until the FSM returns to IDLE.
REQ-027 Minimum latency: req sampled at edge n -> gnt in cycle n+1, mul_init in cycle n+2, rsp_valid one cycle after the mul_done cycle.
REQ-028 mul_done outside WAIT is ignored.
REQ-029 gnt0, gnt1, mul_init, rsp_valid are never high for more than one consecutive cycle.

Reset
REQ-030 rst asserted at any time forces IDLE immediately, independent of clk.
REQ-031 Reset values: gnt0=gnt1=mul_init=rsp_valid=rsp_err=rsp_id=0, mul_A=mul_B=0, rsp_data=0, counter=0, last-served pointer = requester 1, so requester 0 is preferred.
REQ-032 An operation in flight at reset is discarded; no response is produced for it.

Structure
REQ-033 Shared package booth_pkg holds the state enum type and the default WIDTH and TIMEOUT constants.
REQ-034 One sub-module, rr_arb2: a 2-input round-robin arbiter with a pointer input and one-hot grant output; the remaining logic stays in booth_arbiter.

Verification
REQ-035 Single request: req0, a0=3, b0=-2; model done after 10 cycles with result 16'hFFFA -> gnt0 pulse, one mul_init, rsp_valid with rsp_id=0, rsp_data=16'hFFFA, rsp_err=0.
REQ-036 Simultaneous requests after reset: req0 and req1 both high -> requester 0 served first, then requester 1; rsp_id sequence 0,1.
REQ-037 Starvation check: req0 and req1 held high for 4 transactions -> rsp_id sequence 0,1,0,1.
REQ-038 Timeout: mul_done never asserted, TIMEOUT=64 -> rsp_valid 64 cycles after entering WAIT, with rsp_err=1 and rsp_data=0.
REQ-039 Boundary: mul_done asserted on the final timeout cycle -> rsp_err=0 and product captured.
REQ-040 Reset mid-WAIT: rst pulsed during WAIT -> all outputs 0 immediately, no rsp_valid, next req0 is served normally.
